// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared types and coefficient placement helpers for the poly datapath
package poly_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } stream_state_t;

  localparam int BATCH_SIZE = 4;

  // Coefficient c lives in bank c%2 at address c/2.
  function automatic int unsigned bank_of(input int unsigned c);
    return c % 2;
  endfunction

  function automatic int unsigned addr_of(input int unsigned c);
    return c / 2;
  endfunction

endpackage

// File: rtl/dpbram_if.sv
// rtl/dpbram_if.sv - dual-port BRAM bank set interface, four banks with two ports each
interface DPBRAMInterface #(
  parameter int K  = 16,
  parameter int AW = 3
);
  logic [3:0]         en;
  logic [3:0]         we;
  logic [3:0][AW-1:0] addr_a;
  logic [3:0][AW-1:0] addr_b;
  logic [3:0][K-1:0]  di_a;
  logic [3:0][K-1:0]  di_b;
  logic [3:0][K-1:0]  do_a;
  logic [3:0][K-1:0]  do_b;

  modport initiator (
    output en, we, addr_a, addr_b, di_a, di_b,
    input  do_a, do_b
  );

  modport target (
    input  en, we, addr_a, addr_b, di_a, di_b,
    output do_a, do_b
  );
endinterface

// File: rtl/coef_beat_fifo.sv
// rtl/coef_beat_fifo.sv - small synchronous FIFO holding coefficient beats plus batch index
module coef_beat_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 3,
  parameter int OW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [OW-1:0]    occ_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (occ_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((occ_q < OW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (do_push && !do_pop) begin
      occ_d = occ_q + OW'(1);
    end else if (do_pop && !do_push) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/poly_stream_out.sv
// rtl/poly_stream_out.sv - drains a polynomial from the BRAM bank set as a 4-lane valid/ready stream
module poly_stream_out
  import poly_pkg::*;
#(
  parameter int N         = 16,
  parameter int K         = 16,
  parameter int BUF_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  DPBRAMInterface.initiator     bram,
  output logic [BATCH_SIZE*K-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int NB = N / BATCH_SIZE;
  localparam int CW = $clog2(NB + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = (N > 2) ? $clog2(N / 2) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int FW = BATCH_SIZE * K + BW;

  stream_state_t state_q, state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          inflight_q;
  logic [BW-1:0] batch_q;
  logic [OW-1:0] occ;
  logic [OW:0]   credit_used;
  logic [FW-1:0] head;
  logic [FW-1:0] push_data;
  logic          issue;
  logic          pop;
  logic [AW-1:0] addr_lo;
  logic [AW-1:0] addr_hi;

  // Credit check uses only registered occupancy, so m_ready never reaches en.
  assign credit_used = (OW + 1)'(occ) + (OW + 1)'(inflight_q);
  assign issue = (state_q == STREAM) && (rd_cnt_q < CW'(NB)) &&
                 (credit_used < (OW + 1)'(BUF_DEPTH));
  assign pop   = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (pop && m_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (state_q == IDLE) begin
      rd_cnt_d = '0;
    end else if (issue) begin
      rd_cnt_d = rd_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      batch_q    <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      inflight_q <= issue;
      if (issue) begin
        batch_q <= rd_cnt_q[BW-1:0];
      end
    end
  end

  assign addr_lo = AW'(addr_of(32'(rd_cnt_q) * BATCH_SIZE));
  assign addr_hi = AW'(addr_of(32'(rd_cnt_q) * BATCH_SIZE + 2));

  assign bram.en     = {2'b00, issue, issue};
  assign bram.we     = '0;
  assign bram.di_a   = '0;
  assign bram.di_b   = '0;
  assign bram.addr_a = {AW'(0), AW'(0), addr_lo, addr_lo};
  assign bram.addr_b = {AW'(0), AW'(0), addr_hi, addr_hi};

  assign push_data = {batch_q, bram.do_b[1], bram.do_b[0], bram.do_a[1], bram.do_a[0]};

  coef_beat_fifo #(
    .WIDTH (FW),
    .DEPTH (BUF_DEPTH),
    .OW    (OW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (push_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (head)
  );

  assign m_valid = (occ != '0);
  assign m_data  = head[BATCH_SIZE*K-1:0];
  assign m_last  = m_valid && (head[FW-1 -: BW] == BW'(NB - 1));

endmodule

// File: doc/poly_stream_out.md
Name: poly_stream_out

Overview:
- Reader for polynomial BRAM banks written by the poly ops (add/sub/NTT).
- On start, reads all N coefficients from a DPBRAMInterface bank set and emits them as a valid/ready stream, 4 coefficients per beat.
- Used to drain results to host/DMA or to feed stream-based consumers.
- Absorbs the 1-cycle BRAM read latency under backpressure with a small credit-controlled buffer.

Parameters:
- N, `N: polynomial length; multiple of 4.
- K, `K: coefficient width in bits.
- BUF_DEPTH, 3: output buffer entries; must be >= 2. A value of 3 sustains 1 beat/cycle.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin one pass; sampled only in IDLE
- bram  DPBRAMInterface  -  initiator side; drives en/we/addr_a/addr_b/di_a/di_b; reads do_a/do_b
- m_data  output  4*K  lane j at bits [j*K +: K] = coefficient 4b+j
- m_valid  output  1  beat available
- m_ready  input  1  consumer accepts beat when m_valid && m_ready
- m_last  output  1  high with the final beat (b = N/4-1)
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse after final beat accepted

Behaviour:
- Memory layout: coefficient c lives in bank c%2 at address c/2. Bank address width is clog2(N/2).
- Batch b (0..N/4-1) reads:
  - bank0 addr_a=2b, addr_b=2b+1
  - bank1 addr_a=2b, addr_b=2b+1
- Lane mapping: lane0=do_a[0], lane1=do_a[1], lane2=do_b[0], lane3=do_b[1].
- Read data is valid the cycle after en.
- States:
  - IDLE -> STREAM on start.
  - STREAM -> DONE on acceptance of the beat with m_last.
  - DONE -> IDLE unconditionally after 1 cycle.
- Read issue, all of:
  - state==STREAM
  - rd_cnt < N/4
  - occ + inflight < BUF_DEPTH, using registered values only; there is no combinational path from m_ready to en.
- On issue: bank0/bank1 en=1, rd_cnt++, inflight<=1; otherwise inflight<=0.
- Cycle after an issue: the do_a/do_b lanes and the batch index are pushed into the buffer.
- Push and pop in the same cycle: occ unchanged, order preserved.
- m_valid = occ != 0. m_data and m_last come from the buffer head.
- Head data stays stable while m_valid && !m_ready.
- m_last is asserted only on the beat whose batch index == N/4-1.
- Latency: start sampled at edge T0 -> en high in cycle after T0 -> push at next edge -> m_valid high in the 3rd cycle after start sampled.
- Throughput: with m_ready held high, 1 beat/cycle until done. Total pass is N/4 + 3 cycles plus 1 DONE cycle.
- we[0..3] always 0; di_* always 0.
- en[2], en[3] always 0 and their addresses are 0.
- en[0..1] is 0 outside STREAM.
- start outside IDLE is ignored. start held high through DONE begins a new pass on return to IDLE.
- Reset values: state IDLE, rd_cnt 0, inflight 0, occ 0, m_valid 0, m_last 0, busy 0, done 0, all en 0.
- Reset mid-pass flushes the buffer and discards any in-flight read data. The next start restarts at coefficient 0.
- Counter width is clog2(N/4+1), so rd_cnt can reach N/4 without wrap.

Decomposition:
- Shared package poly_pkg holds:
  - stream_state_t {IDLE, STREAM, DONE}
  - BATCH_SIZE=4
  - functions bank_of(c)=c%2 and addr_of(c)=c/2, shared with the poly_ops writers.
- One sub-module, coef_beat_fifo:
  - synchronous FIFO, parameters WIDTH=4*K+clog2(N/4)
  - depth BUF_DEPTH; exposes push, pop, occ, head
  - simultaneous push/pop supported
  - synchronous reset clears occ.

Test Plan:
- N=16, banks preloaded so coef c = c+100, m_ready=1, start pulse:
  - beats {103,102,101,100} (lane3..0), {107..104}, {111..108}, {115..112}
  - m_valid first high 3 cycles after start; m_last only on beat 3
  - done pulses 1 cycle after beat 3; busy falls with it.
- Same preload, m_ready toggling 1,0,1,0:
  - identical 4-beat sequence, no drop/duplicate
  - en never high when occ+inflight==3.
- m_ready=0 for 12 cycles after start:
  - exactly 3 reads issued
  - m_valid held with m_data={103,102,101,100} stable
  - release -> remaining beats complete correctly.
- start pulsed during STREAM -> ignored, single pass of 4 beats. start held high -> second pass begins after DONE, beat 0 repeats {103..100}.
- reset asserted after beat 1 accepted:
  - next cycle m_valid=0, en=0, busy=0, done=0
  - new start streams from {103..100}.
- Whole run: we[0..3]==0, en[2]==en[3]==0, bank0/bank1 addr_b==addr_a+1 whenever en=1.
